// File: rtl/uart_hex_framer.sv
// Sample FIFO for the hex framer: stores SAMPLE_WIDTH-bit words in strict arrival order.
// Latency: a word pushed at edge N is visible at pop_dat after edge N; there is no bypass when full.
// Backpressure: the caller pushes only when count < DEPTH and pops only when count != 0.
module uart_hex_framer_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_dat;
        end
    end

    // Next occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    assign pop_dat = mem_q[rd_q];
    assign count   = cnt_q;
endmodule

// Converts binary samples into uppercase ASCII hex lines (MSB nibble first) for a UART byte stream.
// Latency: a sample accepted into an empty FIFO at edge N is presented as the first hex byte after edge N+1.
// Backpressure: m_valid/m_data hold until m_ready; s_ready drops when the FIFO holds FIFO_DEPTH samples.
module uart_hex_framer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int LINE_END     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_WIDTH-1:0]       s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [7:0]                    m_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int NIB = SAMPLE_WIDTH / 4;
    localparam int NW  = $clog2(NIB + 1);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HEX  = 3'd1,
        CR   = 3'd2,
        LF   = 3'd3,
        SEP  = 3'd4
    } state_t;

    state_t                  state_q;
    logic [SAMPLE_WIDTH-1:0] sh_q;
    logic [NW-1:0]           nib_q;
    logic [SAMPLE_WIDTH-1:0] pop_dat;
    logic [LW-1:0]           level;
    logic                    push;
    logic                    pop;
    logic [3:0]              top_nib;

    assign s_ready    = rst && (level != FULL_LVL);
    assign push       = s_valid && s_ready;
    assign pop        = (state_q == IDLE) && (level != '0);
    assign fifo_level = level;

    uart_hex_framer_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (s_data),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .count    (level)
    );

    // Line sequencer: load a sample, walk its nibbles, then append the line terminator.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            nib_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        sh_q    <= pop_dat;
                        nib_q   <= NW'(NIB);
                        state_q <= HEX;
                    end
                end
                HEX: begin
                    if (m_ready) begin
                        sh_q  <= sh_q << 4;
                        nib_q <= nib_q - 1'b1;
                        if (nib_q == NW'(1)) begin
                            state_q <= (LINE_END != 0) ? CR : SEP;
                        end
                    end
                end
                CR: begin
                    if (m_ready) begin
                        state_q <= LF;
                    end
                end
                LF, SEP: begin
                    if (m_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign top_nib = sh_q[SAMPLE_WIDTH-1 -: 4];
    assign m_valid = (state_q != IDLE);

    // Output byte depends only on state and shift register, never on m_ready.
    always_comb begin
        m_data = 8'h00;
        case (state_q)
            HEX:     m_data = (top_nib <= 4'd9) ? (8'h30 + {4'h0, top_nib})
                                                : (8'h37 + {4'h0, top_nib});
            CR:      m_data = 8'h0D;
            LF:      m_data = 8'h0A;
            SEP:     m_data = 8'h20;
            default: m_data = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_uart_hex_framer.sv
module tb_uart_hex_framer;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [15:0] s_data;
    logic [7:0]  m_data;
    logic [4:0]  fifo_level;
    logic        s_valid2, s_ready2, m_valid2, m_ready2;
    logic [15:0] s_data2;
    logic [7:0]  m_data2;
    logic [4:0]  fifo_level2;

    int tests  = 0;
    int failed = 0;
    logic [7:0] q[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    uart_hex_framer #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(16), .LINE_END(1)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .fifo_level(fifo_level));

    uart_hex_framer #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(16), .LINE_END(0)) dut_sp (
        .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .fifo_level(fifo_level2));

    // Record every byte that will transfer at the coming rising edge.
    always @(negedge clk) begin
        if (rst && m_valid && m_ready)   q.push_back(m_data);
        if (rst && m_valid2 && m_ready2) q2.push_back(m_data2);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] asc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    function automatic logic [47:0] exp_line(input logic [15:0] v);
        return {asc(v[15:12]), asc(v[11:8]), asc(v[7:4]), asc(v[3:0]), 8'h0D, 8'h0A};
    endfunction

    function automatic logic [47:0] got_line(input int base);
        logic [47:0] l = '0;
        for (int j = 0; j < 6; j++) begin
            if (base + j < q.size()) l = {l[39:0], q[base + j]};
            else                     l = {l[39:0], 8'hXX};
        end
        return l;
    endfunction

    initial begin
        int          base;
        int          idx;
        logic        acc;
        logic [39:0] l2;
        logic [15:0] v;

        rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        s_valid2 = 1'b0; s_data2 = '0; m_ready2 = 1'b0;

        // Reset state
        step(); step(); step();
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_level", fifo_level, 5'd0);
        check("rst_s_ready", s_ready, 1'b0);
        rst = 1'b1;
        step();
        check("s_ready_after_rst", s_ready, 1'b1);

        // T1: single sample 0x1A2F with CR LF
        base = q.size();
        m_ready = 1'b1; s_valid = 1'b1; s_data = 16'h1A2F;
        step();
        s_valid = 1'b0;
        check("t1_level_after_push", fifo_level, 5'd1);
        check("t1_m_valid_before_pop", m_valid, 1'b0);
        step();
        check("t1_m_valid_after_pop", m_valid, 1'b1);
        check("t1_first_byte", m_data, 8'h31);
        check("t1_level_after_pop", fifo_level, 5'd0);
        for (int i = 0; i < 6; i++) step();
        check("t1_m_valid_end", m_valid, 1'b0);
        check("t1_byte_count", q.size() - base, 6);
        check("t1_line", got_line(base), 48'h3141_3246_0D0A);

        // T2: LINE_END=0 instance, sample 0x00F9
        m_ready2 = 1'b1; s_valid2 = 1'b1; s_data2 = 16'h00F9;
        step();
        s_valid2 = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("t2_byte_count", q2.size(), 5);
        l2 = '0;
        for (int j = 0; j < 5; j++) l2 = {l2[31:0], (j < q2.size()) ? q2[j] : 8'hXX};
        check("t2_line", l2, 40'h3030_4639_20);
        check("t2_m_valid_end", m_valid2, 1'b0);

        // T3: backpressure on sample 0x1234
        base = q.size();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h1234;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t3_hold_valid", m_valid, 1'b1);
            check("t3_hold_data", m_data, 8'h31);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("t3_line", got_line(base), 48'h3132_3334_0D0A);
        check("t3_m_valid_end", m_valid, 1'b0);

        // T4: fill FIFO with m_ready low, then drain in order
        base = q.size();
        m_ready = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_data = 16'(i);
            step();
        end
        s_data = 16'd17;
        check("t4_level_full", fifo_level, 5'd16);
        check("t4_s_ready_full", s_ready, 1'b0);
        step(); step();
        check("t4_s_ready_still_full", s_ready, 1'b0);
        m_ready = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) begin
            if (s_ready) acc = 1'b1;
            step();
        end
        s_valid = 1'b0;
        check("t4_sample17_accepted", acc, 1'b1);
        for (int c = 0; c < 500 && (q.size() - base) < 108; c++) step();
        check("t4_byte_count", q.size() - base, 108);
        for (int k = 0; k < 18; k++) check("t4_line", got_line(base + 6 * k), exp_line(16'(k)));
        step(); step();
        check("t4_level_empty", fifo_level, 5'd0);

        // T5: random stalls on both sides, 40 samples
        base = q.size();
        idx = 0;
        for (int c = 0; c < 4000 && (q.size() - base) < 240; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (idx < 40) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = 16'(16'hC0DE + idx * 37);
            end else begin
                s_valid = 1'b0;
            end
            acc = s_valid && s_ready;
            step();
            if (acc) idx++;
        end
        s_valid = 1'b0; m_ready = 1'b0;
        check("t5_pushed", idx, 40);
        check("t5_byte_count", q.size() - base, 240);
        for (int k = 0; k < 40; k++) begin
            v = 16'(16'hC0DE + k * 37);
            check("t5_line", got_line(base + 6 * k), exp_line(v));
        end

        // T6: reset in the middle of 0xBEEF with samples queued
        base = q.size();
        m_ready = 1'b0; s_valid = 1'b1;
        s_data = 16'hBEEF; step();
        s_data = 16'h0002; step();
        s_data = 16'h0003; step();
        s_data = 16'h0004; step();
        s_valid = 1'b0;
        m_ready = 1'b1; step(); step();
        m_ready = 1'b0;
        check("t6_sent_two", q.size() - base, 2);
        check("t6_first_two", {(base < q.size()) ? q[base] : 8'hXX,
                               (base + 1 < q.size()) ? q[base + 1] : 8'hXX}, 16'h4245);
        check("t6_level_queued", fifo_level, 5'd3);
        rst = 1'b0;
        #1;
        check("t6_s_ready_in_rst", s_ready, 1'b0);
        step();
        check("t6_m_valid_rst", m_valid, 1'b0);
        check("t6_m_data_rst", m_data, 8'h00);
        check("t6_level_rst", fifo_level, 5'd0);
        check("t6_s_ready_rst_edge", s_ready, 1'b0);
        rst = 1'b1;
        step();
        check("t6_no_stale", m_valid, 1'b0);
        base = q.size();
        m_ready = 1'b1; s_valid = 1'b1; s_data = 16'h0001;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("t6_byte_count", q.size() - base, 6);
        check("t6_line", got_line(base), 48'h3030_3031_0D0A);
        check("t6_m_valid_end", m_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
